pmod_keypad_scanner: RTL and testbench

- Scans a 4x4 hex matrix keypad (Pmod KYPD) on a Basys3 Pmod header and delivers debounced key events to the CPU wrapper.
- Input-side counterpart of the multiplexed seven-segment display: one column at a time is driven active-low and the active-low rows are sampled.
- Single-key presses produce a one-cycle event with a 4-bit hex code; multi-key chords are flagged and suppressed.

---
 rtl/pmod_keypad_scanner.sv | 246 ++++++++++++++++++++++++
 tb/tb_pmod_keypad_scanner.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/pmod_keypad_scanner.sv
// pmod_keypad_scanner
// Scans a 4x4 active-low matrix keypad one column at a time.
// Full scans are debounced into a 16-bit key map, and single-key presses
// are reported as a one-cycle event carrying the key's hex code.
// Multi-key chords are flagged and never reported.
// Key map bit index is {row, col}, which is r*4 + c.
module pmod_keypad_scanner #(
   parameter int SCAN_CYCLES    = 100_000,
   parameter int DEBOUNCE_SCANS = 4
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic [3:0] row,
   output logic [3:0] col,
   output logic [3:0] key_code,
   output logic       key_valid,
   output logic       key_held,
   output logic       multi_key
);

   localparam int CNT_W = $clog2(SCAN_CYCLES);
   localparam int STB_W = $clog2(DEBOUNCE_SCANS + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_CYCLES - 1);
   localparam logic [STB_W-1:0] STB_MAX  = STB_W'(DEBOUNCE_SCANS);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      HELD    = 2'd1,
      LOCKOUT = 2'd2
   } state_t;

   // Number of keys set in a key map.
   function automatic logic [4:0] popcount16(input logic [15:0] v);
      logic [4:0] n;
      n = 5'd0;
      for (int i = 0; i < 16; i++) begin
         n = n + 5'(v[i]);
      end
      return n;
   endfunction

   // Index of the set bit of a one-hot key map.
   function automatic logic [3:0] key_index(input logic [15:0] v);
      logic [3:0] idx;
      idx = 4'd0;
      for (int i = 0; i < 16; i++) begin
         if (v[i]) begin
            idx = 4'(i);
         end
      end
      return idx;
   endfunction

   // Keypad legend: rows 1 2 3 A / 4 5 6 B / 7 8 9 C / 0 F E D.
   function automatic logic [3:0] decode_key(input logic [3:0] idx);
      logic [3:0] k;
      case (idx)
         4'd0:    k = 4'h1;
         4'd1:    k = 4'h2;
         4'd2:    k = 4'h3;
         4'd3:    k = 4'hA;
         4'd4:    k = 4'h4;
         4'd5:    k = 4'h5;
         4'd6:    k = 4'h6;
         4'd7:    k = 4'hB;
         4'd8:    k = 4'h7;
         4'd9:    k = 4'h8;
         4'd10:   k = 4'h9;
         4'd11:   k = 4'hC;
         4'd12:   k = 4'h0;
         4'd13:   k = 4'hF;
         4'd14:   k = 4'hE;
         4'd15:   k = 4'hD;
         default: k = 4'h0;
      endcase
      return k;
   endfunction

   logic [3:0]       row_s1_q, row_s1_d;
   logic [3:0]       row_s2_q, row_s2_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [1:0]       col_idx_q, col_idx_d;
   logic [3:0]       col_q, col_d;
   logic [15:0]      snap_q, snap_d;
   logic             scan_done_q, scan_done_d;
   logic [15:0]      prev_q, prev_d;
   logic [STB_W-1:0] stable_q, stable_d;
   logic [15:0]      map_q, map_d;
   state_t           state_q, state_d;
   logic [3:0]       held_idx_q, held_idx_d;
   logic [3:0]       key_code_q, key_code_d;
   logic             key_valid_q, key_valid_d;
   logic             key_held_q, key_held_d;
   logic             multi_key_q, multi_key_d;
   logic [4:0]       map_pop_s;

   assign map_pop_s = popcount16(map_q);

   // Row synchroniser, column timing and per-column snapshot capture.
   always_comb begin
      row_s1_d    = row;
      row_s2_d    = row_s1_q;
      cnt_d       = cnt_q;
      col_idx_d   = col_idx_q;
      col_d       = col_q;
      snap_d      = snap_q;
      scan_done_d = 1'b0;
      if (cnt_q == CNT_LAST) begin
         cnt_d     = '0;
         col_idx_d = col_idx_q + 2'd1;
         col_d     = ~(4'b0001 << col_idx_d);
         for (int r = 0; r < 4; r++) begin
            snap_d[{2'(r), col_idx_q}] = ~row_s2_q[r];
         end
         scan_done_d = (col_idx_q == 2'd3);
      end else begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   // Debounce: count identical full scans and publish the map once stable.
   always_comb begin
      prev_d   = prev_q;
      stable_d = stable_q;
      map_d    = map_q;
      if (scan_done_q) begin
         if (snap_q == prev_q) begin
            if (stable_q < STB_MAX) begin
               stable_d = stable_q + STB_W'(1);
            end else begin
               stable_d = stable_q;
            end
         end else begin
            stable_d = STB_W'(1);
            prev_d   = snap_q;
         end
         if (stable_d == STB_MAX) begin
            map_d = snap_q;
         end else begin
            map_d = map_q;
         end
      end else begin
         map_d = map_q;
      end
   end

   // Key FSM next-state: report single keys, lock out chords until all released.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (map_q == 16'h0000) begin
               state_d = IDLE;
            end else if (map_pop_s == 5'd1) begin
               state_d = HELD;
            end else begin
               state_d = LOCKOUT;
            end
         end
         HELD: begin
            if (map_q == (16'h0001 << held_idx_q)) begin
               state_d = HELD;
            end else if (map_q == 16'h0000) begin
               state_d = IDLE;
            end else begin
               state_d = LOCKOUT;
            end
         end
         LOCKOUT: begin
            if (map_q == 16'h0000) begin
               state_d = IDLE;
            end else begin
               state_d = LOCKOUT;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Key FSM outputs: event pulse, latched code, held and chord levels.
   always_comb begin
      key_valid_d = (state_q == IDLE) && (state_d == HELD);
      if (key_valid_d) begin
         key_code_d = decode_key(key_index(map_q));
         held_idx_d = key_index(map_q);
      end else begin
         key_code_d = key_code_q;
         held_idx_d = held_idx_q;
      end
      key_held_d  = (state_d == HELD);
      multi_key_d = (map_pop_s > 5'd1);
   end

   // Scan-side registers.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         row_s1_q    <= 4'b1111;
         row_s2_q    <= 4'b1111;
         cnt_q       <= '0;
         col_idx_q   <= 2'd0;
         col_q       <= 4'b1110;
         snap_q      <= 16'h0000;
         scan_done_q <= 1'b0;
         prev_q      <= 16'h0000;
         stable_q    <= '0;
         map_q       <= 16'h0000;
      end else begin
         row_s1_q    <= row_s1_d;
         row_s2_q    <= row_s2_d;
         cnt_q       <= cnt_d;
         col_idx_q   <= col_idx_d;
         col_q       <= col_d;
         snap_q      <= snap_d;
         scan_done_q <= scan_done_d;
         prev_q      <= prev_d;
         stable_q    <= stable_d;
         map_q       <= map_d;
      end
   end

   // FSM state and registered outputs.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q     <= IDLE;
         held_idx_q  <= 4'd0;
         key_code_q  <= 4'h0;
         key_valid_q <= 1'b0;
         key_held_q  <= 1'b0;
         multi_key_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         held_idx_q  <= held_idx_d;
         key_code_q  <= key_code_d;
         key_valid_q <= key_valid_d;
         key_held_q  <= key_held_d;
         multi_key_q <= multi_key_d;
      end
   end

   assign col       = col_q;
   assign key_code  = key_code_q;
   assign key_valid = key_valid_q;
   assign key_held  = key_held_q;
   assign multi_key = multi_key_q;

endmodule

// File: tb/tb_pmod_keypad_scanner.sv
// Directed bench for pmod_keypad_scanner with a behavioural keypad matrix.
module tb_pmod_keypad_scanner;

   localparam int SCAN = 64;              // 4 columns x 16 cycles
   localparam int WIN  = 4 * SCAN + 3;    // latency bound

   logic        clk = 1'b0;
   logic        reset_n;
   logic [3:0]  row;
   logic [3:0]  col;
   logic [3:0]  key_code;
   logic        key_valid;
   logic        key_held;
   logic        multi_key;
   logic [15:0] pressed;

   int checks = 0;
   int errors = 0;
   int pulses;
   logic held_seen;
   logic multi_seen;

   always #5 clk = ~clk;

   pmod_keypad_scanner #(.SCAN_CYCLES(16), .DEBOUNCE_SCANS(3)) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .row       (row),
      .col       (col),
      .key_code  (key_code),
      .key_valid (key_valid),
      .key_held  (key_held),
      .multi_key (multi_key)
   );

   // Keypad matrix: a pressed key pulls its row low while its column is driven low.
   always_comb begin
      row = 4'b1111;
      for (int r = 0; r < 4; r++) begin
         for (int c = 0; c < 4; c++) begin
            if (pressed[{2'(r), 2'(c)}] && !col[2'(c)]) begin
               row[2'(r)] = 1'b0;
            end
         end
      end
   end

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic clear_obs();
      pulses     = 0;
      held_seen  = 1'b0;
      multi_seen = 1'b0;
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(negedge clk);
         if (key_valid === 1'b1) pulses++;
         if (key_held === 1'b1) held_seen = 1'b1;
         if (multi_key === 1'b1) multi_seen = 1'b1;
      end
   endtask

   initial begin
      logic [3:0] col_exp [5];
      int n;
      col_exp[0] = 4'b1110; col_exp[1] = 4'b1101; col_exp[2] = 4'b1011;
      col_exp[3] = 4'b0111; col_exp[4] = 4'b1110;
      pressed = 16'h0000;
      reset_n = 1'b0;
      clear_obs();

      // 1. reset and idle scanning
      tick(4);
      check("rst_col", 16'(col), 16'h000E);
      check("rst_code", 16'(key_code), 16'h0);
      check("rst_valid", 16'(key_valid), 16'h0);
      check("rst_held", 16'(key_held), 16'h0);
      check("rst_multi", 16'(multi_key), 16'h0);
      reset_n = 1'b1;
      tick(8);
      check("col_seq0", 16'(col), 16'(col_exp[0]));
      for (int i = 1; i < 5; i++) begin
         tick(16);
         check("col_seq", 16'(col), 16'(col_exp[i]));
      end
      clear_obs();
      tick(1000);
      check("idle_pulses", 16'(pulses), 16'd0);
      check("idle_held", 16'(held_seen), 16'd0);
      check("idle_multi", 16'(multi_seen), 16'd0);
      check("idle_code", 16'(key_code), 16'h0);

      // 2. steady '5' (r1,c1 -> bit 5)
      clear_obs();
      pressed = 16'h0020;
      tick(WIN);
      check("k5_pulses", 16'(pulses), 16'd1);
      check("k5_code", 16'(key_code), 16'h5);
      check("k5_held", 16'(key_held), 16'd1);
      tick(200);
      check("k5_norepeat", 16'(pulses), 16'd1);
      clear_obs();
      pressed = 16'h0000;
      tick(WIN);
      check("k5_rel_held", 16'(key_held), 16'd0);
      check("k5_rel_pulses", 16'(pulses), 16'd0);
      check("k5_rel_code", 16'(key_code), 16'h5);

      // 3. bouncing 'D' (r3,c3 -> bit 15), then steady
      clear_obs();
      for (int i = 0; i < 15; i++) begin
         pressed = (i % 2 == 0) ? 16'h8000 : 16'h0000;
         tick(20);
      end
      check("bounce_pulses", 16'(pulses), 16'd0);
      clear_obs();
      pressed = 16'h8000;
      tick(WIN);
      check("kd_pulses", 16'(pulses), 16'd1);
      check("kd_code", 16'(key_code), 16'hD);
      pressed = 16'h0000;
      tick(WIN);

      // 4. chord '1'+'2' (bits 0,1)
      clear_obs();
      pressed = 16'h0003;
      tick(WIN);
      check("chord_multi", 16'(multi_key), 16'd1);
      check("chord_pulses", 16'(pulses), 16'd0);
      check("chord_held", 16'(held_seen), 16'd0);
      pressed = 16'h0002;
      tick(WIN);
      check("lock_multi", 16'(multi_key), 16'd0);
      check("lock_pulses", 16'(pulses), 16'd0);
      check("lock_held", 16'(key_held), 16'd0);
      pressed = 16'h0000;
      tick(WIN);
      check("lock_rel_pulses", 16'(pulses), 16'd0);
      clear_obs();
      pressed = 16'h0002;
      tick(WIN);
      check("k2_pulses", 16'(pulses), 16'd1);
      check("k2_code", 16'(key_code), 16'h2);
      pressed = 16'h0000;
      tick(WIN);

      // 5. '0' (bit 12) for a single scan only
      clear_obs();
      pressed = 16'h1000;
      tick(SCAN);
      pressed = 16'h0000;
      tick(WIN);
      check("short_pulses", 16'(pulses), 16'd0);
      check("short_held", 16'(held_seen), 16'd0);
      check("short_code", 16'(key_code), 16'h2);

      // 6. reset while 'A' (bit 3) is held
      clear_obs();
      pressed = 16'h0008;
      n = 0;
      while (key_held !== 1'b1 && n < WIN) begin
         tick(1);
         n++;
      end
      check("ka_held", 16'(key_held), 16'd1);
      check("ka_code", 16'(key_code), 16'hA);
      reset_n = 1'b0;
      tick(3);
      check("mid_rst_col", 16'(col), 16'h000E);
      check("mid_rst_code", 16'(key_code), 16'h0);
      check("mid_rst_held", 16'(key_held), 16'd0);
      check("mid_rst_valid", 16'(key_valid), 16'd0);
      check("mid_rst_multi", 16'(multi_key), 16'd0);
      clear_obs();
      reset_n = 1'b1;
      tick(WIN);
      check("ka2_pulses", 16'(pulses), 16'd1);
      check("ka2_code", 16'(key_code), 16'hA);
      check("ka2_held", 16'(key_held), 16'd1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
